ubcd_scan_controller: RTL

//  Time-multiplexed scan controller for a DIGITS-wide 7-segment display built around one shared

---
 rtl/ubcd_pkg.sv | 30 +++
 rtl/ubcd_zero_blank.sv | 34 +++
 rtl/ubcd_scan_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ubcd_pkg.sv
// ---------------------------------------------------------------------------
// Package: ubcd_pkg
// Purpose: Shared constants and types for the universal BCD decoder scan
//          controller: decoder code-set selectors, BCD digit width and the
//          scan state encoding.
// Contents:
//   VER_*         3-bit version codes understood by universal_bcd_decoder
//   BCD_W         width of one BCD digit
//   scan_state_t  IDLE / BLANK / ON scan states
// ---------------------------------------------------------------------------
package ubcd_pkg;

    localparam logic [2:0] VER_RCA         = 3'd0;
    localparam logic [2:0] VER_TI          = 3'd1;
    localparam logic [2:0] VER_NSC         = 3'd2;
    localparam logic [2:0] VER_TOSHIBA     = 3'd3;
    localparam logic [2:0] VER_LINES       = 3'd4;
    localparam logic [2:0] VER_ELEKTRONIKA = 3'd5;
    localparam logic [2:0] VER_CODEB       = 3'd6;
    localparam logic [2:0] VER_HEX         = 3'd7;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/ubcd_zero_blank.sv
// ---------------------------------------------------------------------------
// Module: ubcd_zero_blank
// Purpose: Combinational leading-zero suppression mask. Digit i is blanked
//          when suppression is enabled, i is not the least significant
//          digit, and every digit from the MSB down to i is zero.
// Ports:
//   digits  in   DIGITS x BCD_W  frame digits, index DIGITS-1 is the MSB
//   lz_en   in   1               1 = suppress leading zeros
//   blank   out  DIGITS          1 = this digit should be blanked
// ---------------------------------------------------------------------------
module ubcd_zero_blank
    import ubcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGITS-1:0][BCD_W-1:0] digits,
    input  logic                         lz_en,
    output logic [DIGITS-1:0]            blank
);

    logic zero_run;

    // Ripple from the MSB downwards; the chain breaks at the first nonzero
    // digit. Digit 0 is left out so an all-zero frame still shows "0".
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (digits[i] == '0);
            blank[i] = lz_en & zero_run;
        end
    end

endmodule

// File: rtl/ubcd_scan_controller.sv
// ---------------------------------------------------------------------------
// Module: ubcd_scan_controller
// Purpose: Time-multiplexed scan controller for a DIGITS-wide 7-segment
//          display sharing one universal_bcd_decoder. Double-buffers a BCD
//          frame (staging -> shadow at frame boundaries), scans digits with
//          a blanking guard before each lit slot, and drives the decoder's
//          value/version/RBI/BI/LT inputs plus one-hot digit enables.
// Configuration:
//   UBCD_SCAN_DIM_EN  adds dim[3:0]; the lit slot is split into 16 equal
//                     sub-phases and only sub-phases 0..dim are lit.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   en           scan enable, low forces IDLE
//   ld, din      load strobe and 4*DIGITS-bit BCD frame (digit i at 4i)
//   version      decoder code-set select, registered to dec_version
//   lz_en        leading-zero suppression enable
//   lt_n         lamp test (active-low), registered to dec_lt
//   dim          brightness, only with UBCD_SCAN_DIM_EN
//   dec_value    digit value to decoder {D,C,B,A}
//   dec_version  code set to decoder
//   dec_rbi      decoder RBI, 0 blanks this zero digit
//   dec_bi       decoder BI, 0 forces all segments off
//   dec_lt       decoder LT
//   dig_en       one-hot digit drive, zero while blanked
//   frame_tick   pulse on the last lit cycle of the last digit
// ---------------------------------------------------------------------------
module ubcd_scan_controller
    import ubcd_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      ld,
    input  logic [BCD_W*DIGITS-1:0]   din,
    input  logic [2:0]                version,
    input  logic                      lz_en,
    input  logic                      lt_n,
`ifdef UBCD_SCAN_DIM_EN
    input  logic [3:0]                dim,
`endif
    output logic [BCD_W-1:0]          dec_value,
    output logic [2:0]                dec_version,
    output logic                      dec_rbi,
    output logic                      dec_bi,
    output logic                      dec_lt,
    output logic [DIGITS-1:0]         dig_en,
    output logic                      frame_tick
);

    localparam int SLOT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW       = $clog2(SLOT_MAX) + 1;
    localparam int IW       = $clog2(DIGITS);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    scan_state_t                  state, state_n;
    logic [CW-1:0]                cnt, cnt_n;
    logic [IW-1:0]                idx, idx_n;
    logic [DIGITS-1:0][BCD_W-1:0] staging, staging_n;
    logic [DIGITS-1:0][BCD_W-1:0] shadow, shadow_n;
    logic                         pending, pending_n;
    logic [DIGITS-1:0]            blank_mask;
    logic                         slot_lit;

    logic [BCD_W-1:0]             dec_value_n;
    logic                         dec_rbi_n;
    logic                         dec_bi_n;
    logic [DIGITS-1:0]            dig_en_n;
    logic                         frame_tick_n;

    // Suppression mask is taken from the shadow as it will be next cycle, so
    // the first slot of a freshly swapped frame already sees the new data.
    ubcd_zero_blank #(
        .DIGITS (DIGITS)
    ) u_zero_blank (
        .digits (shadow_n),
        .lz_en  (lz_en),
        .blank  (blank_mask)
    );

`ifdef UBCD_SCAN_DIM_EN
    localparam int SUB = PRESCALE / 16;

    // A slot cycle is lit while it falls inside sub-phases 0..dim, i.e.
    // before (dim+1) sub-phases worth of cycles have elapsed.
    assign slot_lit = (32'(cnt_n) < ((32'(dim) + 32'd1) * 32'(SUB)));
`else
    assign slot_lit = 1'b1;
`endif

    // Scan sequencing: BLANK guard then ON slot per digit; dropping en
    // returns to IDLE with the position cleared from any state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            BLANK: begin
                if (cnt == BLK_LAST) begin
                    state_n = ON;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ON: begin
                if (cnt == PRE_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end
    end

    // Double buffer: the shadow only swaps on the frame_tick cycle, and a
    // load arriving on that very cycle bypasses staging.
    always_comb begin
        staging_n = staging;
        shadow_n  = shadow;
        pending_n = pending;
        if (frame_tick) begin
            if (ld) begin
                shadow_n = din;
            end else if (pending) begin
                shadow_n = staging;
            end
            pending_n = 1'b0;
        end
        if (ld) begin
            staging_n = din;
            if (!frame_tick) begin
                pending_n = 1'b1;
            end
        end
    end

    // Output targets are derived from the next state so the registered
    // outputs line up with the registered state. Value and RBI latch on
    // BLANK entry and hold through the slot.
    always_comb begin
        dig_en_n     = '0;
        dec_bi_n     = 1'b0;
        frame_tick_n = 1'b0;
        dec_value_n  = dec_value;
        dec_rbi_n    = dec_rbi;
        if (state_n == ON && slot_lit) begin
            dig_en_n = DIGITS'(1) << idx_n;
            dec_bi_n = 1'b1;
        end
        if (state_n == ON && cnt_n == PRE_LAST && idx_n == IDX_LAST) begin
            frame_tick_n = 1'b1;
        end
        if (state_n == BLANK && state != BLANK) begin
            dec_value_n = shadow_n[idx_n];
            dec_rbi_n   = ~blank_mask[idx_n];
        end
    end

    // All state and outputs registered together with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            staging     <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            dec_value   <= '0;
            dec_version <= '0;
            dec_rbi     <= 1'b1;
            dec_bi      <= 1'b0;
            dec_lt      <= 1'b1;
            dig_en      <= '0;
            frame_tick  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            staging     <= staging_n;
            shadow      <= shadow_n;
            pending     <= pending_n;
            dec_value   <= dec_value_n;
            dec_version <= version;
            dec_rbi     <= dec_rbi_n;
            dec_bi      <= dec_bi_n;
            dec_lt      <= lt_n;
            dig_en      <= dig_en_n;
            frame_tick  <= frame_tick_n;
        end
    end

endmodule
